// File: rtl/axis_testpattern_checker_if.sv
// -----------------------------------------------------------------------------
// axis_testpattern_checker_if
// Purpose : AXI4-Stream data channel bundle (tdata/tvalid/tready) between the
//           counter test-pattern generator and the test-pattern checker.
// Signals : tdata  [S00_AXIS_TDATA_WIDTH-1:0]  pattern data (master -> slave)
//           tvalid                             data valid   (master -> slave)
//           tready                             sink ready   (slave -> master)
// Modports: master (generator side), slave (checker side)
//
// Handshake: a beat transfers on every rising clock edge where tvalid and
// tready are both high. Once tvalid is raised the master holds tdata stable
// until that transfer. The slave may drop tready at any time, and a stall on
// either side is never treated as an error.
// -----------------------------------------------------------------------------
interface axis_testpattern_checker_if #(
   parameter int S00_AXIS_TDATA_WIDTH = 32
) ();
   logic [S00_AXIS_TDATA_WIDTH-1:0] tdata;
   logic                            tvalid;
   logic                            tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_testpattern_checker.sv
// -----------------------------------------------------------------------------
// axis_testpattern_checker
// Purpose : AXI4-Stream sink that locks onto a counter test pattern, counts
//           accepted beats and sequence errors, and captures the most recent
//           mismatch (expected and received values).
// Ports   : s_axis_aclk    clock
//           s_axis_areset  asynchronous active-high reset
//           enable         allow acceptance; low drops tready one cycle later
//           clear          synchronous clear of counters, captures and lock
//           s_axis         stream slave (tdata, tvalid, tready registered)
//           locked         high while in LOCKED
//           error_pulse    one-cycle pulse per detected error (registered)
//           error_count    saturating error count
//           beat_count     accepted beats, wraps at 2^32
//           last_expected  expected value at the most recent error
//           last_received  received value at the most recent error
//           o_dbg_state    current FSM state (0 = SEARCH, 1 = LOCKED)
// Option  : define AXIS_TESTPATTERN_CHECKER_THROTTLE_EN to force tready low for
//           one cycle in every THROTTLE_PERIOD cycles (upstream backpressure).
// -----------------------------------------------------------------------------
module axis_testpattern_checker #(
   parameter int S00_AXIS_TDATA_WIDTH = 32,
   parameter int COUNTER_START        = 0,
   parameter int COUNTER_END          = 255,
   parameter int COUNTER_INCR         = 1,
   parameter int LOCK_BEATS           = 4,
   parameter int ERR_CNT_WIDTH        = 16,
   parameter int THROTTLE_PERIOD      = 5
) (
   input  logic                            s_axis_aclk,
   input  logic                            s_axis_areset,
   input  logic                            enable,
   input  logic                            clear,
   axis_testpattern_checker_if.slave       s_axis,
   output logic                            locked,
   output logic                            error_pulse,
   output logic [ERR_CNT_WIDTH-1:0]        error_count,
   output logic [31:0]                     beat_count,
   output logic [S00_AXIS_TDATA_WIDTH-1:0] last_expected,
   output logic [S00_AXIS_TDATA_WIDTH-1:0] last_received,
   output logic                            o_dbg_state
);
   localparam int W    = S00_AXIS_TDATA_WIDTH;
   localparam int MC_W = $clog2(LOCK_BEATS);

   // All pattern arithmetic is signed at the data width.
   localparam logic signed [W-1:0] C_START   = W'(COUNTER_START);
   localparam logic signed [W-1:0] C_END     = W'(COUNTER_END);
   localparam logic signed [W-1:0] C_INCR    = W'(COUNTER_INCR);
   localparam logic signed [W-1:0] C_WRAP_TH = C_END - C_INCR + W'(1);
   localparam logic signed [W-1:0] C_WRAP_AD = C_INCR - (C_END - C_START) - W'(1);
   localparam logic [MC_W-1:0]     C_MC_LOCK = MC_W'(LOCK_BEATS - 1);

   typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t                    r_state, w_state_nxt;
   logic [MC_W-1:0]           r_match_cnt, w_match_cnt_nxt;
   logic signed [W-1:0]       r_expected, w_expected_nxt;
   logic                      r_error_pulse, w_error_pulse_nxt;
   logic [ERR_CNT_WIDTH-1:0]  r_error_count, w_error_count_nxt;
   logic [31:0]               r_beat_count, w_beat_count_nxt;
   logic [W-1:0]              r_last_exp, w_last_exp_nxt;
   logic [W-1:0]              r_last_rcv, w_last_rcv_nxt;
   logic                      r_tready, w_tready_nxt;

   logic                      w_acc;
   logic signed [W-1:0]       w_data;
   logic                      w_good;

   // Successor of x in the counter sequence, folding back past COUNTER_END.
   function automatic logic signed [W-1:0] f_next(input logic signed [W-1:0] x);
      return (x >= C_WRAP_TH) ? (x + C_WRAP_AD) : (x + C_INCR);
   endfunction

   assign w_acc  = s_axis.tvalid & r_tready;
   assign w_data = signed'(s_axis.tdata);
   assign w_good = (w_data == r_expected) && (w_data >= C_START) && (w_data <= C_END);

`ifdef AXIS_TESTPATTERN_CHECKER_THROTTLE_EN
   localparam int TW = $clog2(THROTTLE_PERIOD);
   localparam logic [TW-1:0] C_THR_LAST = TW'(THROTTLE_PERIOD - 1);

   logic [TW-1:0] r_thr_cnt;

   // Free-running, independent of enable and clear.
   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset)
         r_thr_cnt <= '0;
      else if (r_thr_cnt == C_THR_LAST)
         r_thr_cnt <= '0;
      else
         r_thr_cnt <= r_thr_cnt + TW'(1);
   end

   assign w_tready_nxt = enable & (r_thr_cnt != C_THR_LAST);
`else
   assign w_tready_nxt = enable;
`endif

   // Next-state and datapath update. clear wins over a same-cycle beat.
   always_comb begin
      w_state_nxt       = r_state;
      w_match_cnt_nxt   = r_match_cnt;
      w_expected_nxt    = r_expected;
      w_error_pulse_nxt = 1'b0;
      w_error_count_nxt = r_error_count;
      w_beat_count_nxt  = r_beat_count;
      w_last_exp_nxt    = r_last_exp;
      w_last_rcv_nxt    = r_last_rcv;

      if (clear) begin
         w_state_nxt       = ST_SEARCH;
         w_match_cnt_nxt   = '0;
         w_expected_nxt    = C_START;
         w_error_count_nxt = '0;
         w_beat_count_nxt  = '0;
         w_last_exp_nxt    = '0;
         w_last_rcv_nxt    = '0;
      end else if (w_acc) begin
         w_beat_count_nxt = r_beat_count + 32'd1;
         case (r_state)
            ST_SEARCH: begin
               // Any beat seeds the prediction; a run only grows once seeded.
               w_expected_nxt = f_next(w_data);
               if (w_good && (r_match_cnt != '0)) begin
                  if (r_match_cnt == C_MC_LOCK)
                     w_state_nxt = ST_LOCKED;
                  else
                     w_match_cnt_nxt = r_match_cnt + MC_W'(1);
               end else begin
                  w_match_cnt_nxt = MC_W'(1);
               end
            end
            ST_LOCKED: begin
               if (w_good) begin
                  w_expected_nxt = f_next(r_expected);
               end else begin
                  // Record the miss and resync on what actually arrived.
                  w_error_pulse_nxt = 1'b1;
                  if (r_error_count != '1)
                     w_error_count_nxt = r_error_count + ERR_CNT_WIDTH'(1);
                  w_last_exp_nxt = r_expected;
                  w_last_rcv_nxt = s_axis.tdata;
                  w_expected_nxt = f_next(w_data);
               end
            end
            default: w_state_nxt = ST_SEARCH;
         endcase
      end
   end

   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         r_state       <= ST_SEARCH;
         r_match_cnt   <= '0;
         r_expected    <= C_START;
         r_error_pulse <= 1'b0;
         r_error_count <= '0;
         r_beat_count  <= '0;
         r_last_exp    <= '0;
         r_last_rcv    <= '0;
         r_tready      <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_match_cnt   <= w_match_cnt_nxt;
         r_expected    <= w_expected_nxt;
         r_error_pulse <= w_error_pulse_nxt;
         r_error_count <= w_error_count_nxt;
         r_beat_count  <= w_beat_count_nxt;
         r_last_exp    <= w_last_exp_nxt;
         r_last_rcv    <= w_last_rcv_nxt;
         r_tready      <= w_tready_nxt;
      end
   end

   assign s_axis.tready = r_tready;
   assign locked        = (r_state == ST_LOCKED);
   assign o_dbg_state   = r_state;
   assign error_pulse   = r_error_pulse;
   assign error_count   = r_error_count;
   assign beat_count    = r_beat_count;
   assign last_expected = r_last_exp;
   assign last_received = r_last_rcv;
endmodule

// File: tb/tb_axis_testpattern_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_testpattern_checker
// Directed bench for axis_testpattern_checker. dut_a uses the default pattern
// (0..255 step 1); dut_b uses start 10, end 20, step 3.
// -----------------------------------------------------------------------------
module tb_axis_testpattern_checker;
   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic en_a  = 1'b0;
   logic clr_a = 1'b0;
   logic en_b  = 1'b1;
   logic clr_b = 1'b0;

   axis_testpattern_checker_if #(.S00_AXIS_TDATA_WIDTH(32)) bus_a ();
   axis_testpattern_checker_if #(.S00_AXIS_TDATA_WIDTH(32)) bus_b ();

   logic        locked_a, pulse_a, dbg_a;
   logic [15:0] ecnt_a;
   logic [31:0] bcnt_a, lexp_a, lrcv_a;
   logic        locked_b, pulse_b, dbg_b;
   logic [15:0] ecnt_b;
   logic [31:0] bcnt_b, lexp_b, lrcv_b;

   axis_testpattern_checker dut_a (
      .s_axis_aclk   (clk),
      .s_axis_areset (rst),
      .enable        (en_a),
      .clear         (clr_a),
      .s_axis        (bus_a),
      .locked        (locked_a),
      .error_pulse   (pulse_a),
      .error_count   (ecnt_a),
      .beat_count    (bcnt_a),
      .last_expected (lexp_a),
      .last_received (lrcv_a),
      .o_dbg_state   (dbg_a)
   );

   axis_testpattern_checker #(
      .COUNTER_START (10),
      .COUNTER_END   (20),
      .COUNTER_INCR  (3)
   ) dut_b (
      .s_axis_aclk   (clk),
      .s_axis_areset (rst),
      .enable        (en_b),
      .clear         (clr_b),
      .s_axis        (bus_b),
      .locked        (locked_b),
      .error_pulse   (pulse_b),
      .error_count   (ecnt_b),
      .beat_count    (bcnt_b),
      .last_expected (lexp_b),
      .last_received (lrcv_b),
      .o_dbg_state   (dbg_b)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present v and wait (bounded) for the edge that accepts it; tvalid stays high.
   task automatic send_a(input logic [31:0] v);
      logic a;
      int   g;
      a = 1'b0;
      g = 0;
      bus_a.tdata  = v;
      bus_a.tvalid = 1'b1;
      while (!a && g < 50) begin
         @(negedge clk);
         a = bus_a.tready;
         @(posedge clk);
         #1;
         g++;
      end
      chk("accept_a", 32'(a), 32'd1);
   endtask

   task automatic send_b(input logic [31:0] v);
      logic a;
      int   g;
      a = 1'b0;
      g = 0;
      bus_b.tdata  = v;
      bus_b.tvalid = 1'b1;
      while (!a && g < 50) begin
         @(negedge clk);
         a = bus_b.tready;
         @(posedge clk);
         #1;
         g++;
      end
      chk("accept_b", 32'(a), 32'd1);
   endtask

   task automatic chk_cap(input string tag);
      logic [31:0] e, r;
      e = exp_q.pop_front();
      r = exp_q.pop_front();
      chk({tag, "_last_expected"}, lexp_a, e);
      chk({tag, "_last_received"}, lrcv_a, r);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   logic [31:0] vb [9];
   int          n;
   int          guard;
   logic        acc;

   initial begin
      bus_a.tdata  = '0;
      bus_a.tvalid = 1'b0;
      bus_b.tdata  = '0;
      bus_b.tvalid = 1'b0;
      vb = '{32'd10, 32'd13, 32'd16, 32'd19, 32'd11, 32'd14, 32'd17, 32'd20, 32'd12};

      // Reset state
      @(negedge clk);
      chk("rst_tready",  32'(bus_a.tready), 32'd0);
      chk("rst_locked",  32'(locked_a), 32'd0);
      chk("rst_pulse",   32'(pulse_a), 32'd0);
      chk("rst_ecnt",    32'(ecnt_a), 32'd0);
      chk("rst_bcnt",    bcnt_a, 32'd0);
      chk("rst_lexp",    lexp_a, 32'd0);
      chk("rst_lrcv",    lrcv_a, 32'd0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      en_a = 1'b1;

      // 1: continuous 0,1,2,... over 300 beats including wrap 255 -> 0
      for (int i = 0; i < 300; i++) begin
         send_a(32'(i % 256));
         if (i == 2) chk("t1_not_locked_after_3", 32'(locked_a), 32'd0);
         if (i == 3) chk("t1_locked_after_4", 32'(locked_a), 32'd1);
      end
      bus_a.tvalid = 1'b0;
      step();
      chk("t1_ecnt", 32'(ecnt_a), 32'd0);
      chk("t1_bcnt", bcnt_a, 32'd300);
      chk("t1_locked", 32'(locked_a), 32'd1);

      // clear while idle
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      chk("clr_locked", 32'(locked_a), 32'd0);
      chk("clr_bcnt", bcnt_a, 32'd0);

      // 3: single skipped value 8
      for (int i = 0; i < 8; i++) send_a(32'(i));
      chk("t3_locked", 32'(locked_a), 32'd1);
      chk("t3_no_pulse_yet", 32'(pulse_a), 32'd0);
      send_a(32'd9);
      exp_q.push_back(32'd8);
      exp_q.push_back(32'd9);
      chk("t3_pulse", 32'(pulse_a), 32'd1);
      chk("t3_ecnt", 32'(ecnt_a), 32'd1);
      chk_cap("t3");
      send_a(32'd10);
      chk("t3_pulse_10", 32'(pulse_a), 32'd0);
      send_a(32'd11);
      chk("t3_pulse_11", 32'(pulse_a), 32'd0);
      chk("t3_ecnt_final", 32'(ecnt_a), 32'd1);
      chk("t3_still_locked", 32'(locked_a), 32'd1);
      bus_a.tvalid = 1'b0;
      step();

      // 4: enable drop with a beat in the intervening cycle, then random gaps
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      bus_a.tdata  = 32'd0;
      bus_a.tvalid = 1'b1;
      en_a = 1'b0;
      step();
      chk("t4_inflight_beat", bcnt_a, 32'd1);
      chk("t4_tready_fell", 32'(bus_a.tready), 32'd0);
      bus_a.tdata = 32'd1;
      step();
      step();
      chk("t4_frozen_bcnt", bcnt_a, 32'd1);
      n = 1;
      guard = 0;
      while (n < 1000 && guard < 20000) begin
         bus_a.tvalid = ($urandom_range(0, 3) != 0);
         bus_a.tdata  = 32'(n % 256);
         if ($urandom_range(0, 7) == 0) en_a = ~en_a;
         @(negedge clk);
         acc = bus_a.tvalid & bus_a.tready;
         @(posedge clk);
         #1;
         if (acc) n++;
         guard++;
      end
      bus_a.tvalid = 1'b0;
      en_a = 1'b1;
      step();
      chk("t4_beats_sent", 32'(n), 32'd1000);
      chk("t4_ecnt", 32'(ecnt_a), 32'd0);
      chk("t4_bcnt", bcnt_a, 32'd1000);
      chk("t4_locked", 32'(locked_a), 32'd1);

      // 5a: three errors while locked (expected continues at next(231) = 232)
      send_a(32'd240);
      exp_q.push_back(32'd232);
      exp_q.push_back(32'd240);
      chk_cap("t5_err1");
      send_a(32'd250);
      send_a(32'd5);
      exp_q.push_back(32'd251);
      exp_q.push_back(32'd5);
      bus_a.tvalid = 1'b0;
      step();
      chk("t5_ecnt3", 32'(ecnt_a), 32'd3);
      chk_cap("t5_err3");

      // 5b: asynchronous reset mid-operation
      rst = 1'b1;
      #1;
      chk("t5_rst_tready", 32'(bus_a.tready), 32'd0);
      chk("t5_rst_locked", 32'(locked_a), 32'd0);
      chk("t5_rst_ecnt", 32'(ecnt_a), 32'd0);
      chk("t5_rst_bcnt", bcnt_a, 32'd0);
      chk("t5_rst_lexp", lexp_a, 32'd0);
      chk("t5_rst_lrcv", lrcv_a, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_tready_after_release", 32'(bus_a.tready), 32'd0);
      step();
      chk("t5_tready_back", 32'(bus_a.tready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         send_a(32'(i));
         if (i == 2) chk("t5_relock_pending", 32'(locked_a), 32'd0);
      end
      chk("t5_relocked", 32'(locked_a), 32'd1);

      // 5c: clear has priority over a same-cycle beat
      bus_a.tdata  = 32'd4;
      bus_a.tvalid = 1'b1;
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      bus_a.tvalid = 1'b0;
      chk("t5_clr_bcnt", bcnt_a, 32'd0);
      chk("t5_clr_locked", 32'(locked_a), 32'd0);
      chk("t5_clr_ecnt", 32'(ecnt_a), 32'd0);
      chk("t5_clr_tready", 32'(bus_a.tready), 32'd1);

      // 2: start 10, end 20, step 3 with wraps 19 -> 11 and 20 -> 12
      for (int i = 0; i < 9; i++) begin
         send_b(vb[i]);
         if (i == 2) chk("t2_not_locked", 32'(locked_b), 32'd0);
         if (i == 3) chk("t2_locked", 32'(locked_b), 32'd1);
      end
      bus_b.tvalid = 1'b0;
      step();
      chk("t2_ecnt", 32'(ecnt_b), 32'd0);
      chk("t2_bcnt", bcnt_b, 32'd9);
      chk("t2_still_locked", 32'(locked_b), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
